instruction_prefetch_queue: RTL and testbench

Parametrised successor to the combinational InstructionMemory. Holds program words in a synchronous single-port array and fetches sequentially from an internal program counter into a small prefetch queue. Instructions go to the decode stage over a Valid/Ready handshake. A redirect input serves branches and jumps, and a load port writes the program image at run time.

---
 rtl/instruction_prefetch_queue.sv | 123 ++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction fetcher: synchronous program memory feeding a small
// prefetch FIFO that hands (address, instruction) pairs to decode over valid/ready.
module instruction_prefetch_queue #(
  parameter int l      = 16,
  parameter int AW     = 6,
  parameter int QDEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_enable_i,
  input  logic [l-1:0] load_address_i,
  input  logic [l-1:0] load_data_i,
  input  logic         redirect_i,
  input  logic [l-1:0] redirect_address_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [l-1:0] instruction_o,
  output logic [l-1:0] instruction_address_o
);

  localparam int DEPTH = 2 ** AW;
  localparam int QAW   = $clog2(QDEPTH);
  localparam int CW    = QAW + 1;
  localparam int OW    = CW + 1;

  logic [l-1:0]   mem_q [DEPTH];
  logic [l-1:0]   rd_data_q;

  logic [l-1:0]   pc_q, pc_d;
  logic [l-1:0]   rd_addr_q, rd_addr_d;
  logic           inflight_q, inflight_d;

  logic [l-1:0]   qdata_q [QDEPTH];
  logic [l-1:0]   qaddr_q [QDEPTH];
  logic [QAW-1:0] head_q, head_d;
  logic [QAW-1:0] tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic           pop;
  logic           push;
  logic           issue;
  logic [OW-1:0]  occupancy;

  // Only the low AW bits of the load address select a word.
  logic           load_addr_unused;
  assign load_addr_unused = ^load_address_i[l-1:AW];

  assign valid_o               = (count_q != '0);
  assign instruction_o         = qdata_q[head_q];
  assign instruction_address_o = qaddr_q[head_q];

  always_comb begin
    pop        = valid_o && ready_i && !redirect_i;
    push       = inflight_q && !redirect_i;
    // Slots already committed after this edge: queued + in flight - leaving.
    occupancy  = OW'(count_q) + OW'(inflight_q) - OW'(pop);
    issue      = !load_enable_i && !redirect_i && (occupancy < OW'(QDEPTH));

    pc_d       = pc_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect_i) begin
      pc_d       = redirect_address_i;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d      = pc_q + 1'b1;
        rd_addr_d = pc_q;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Program memory is never reset so a loaded image survives Reset.
  always_ff @(posedge clk_i) begin
    if (load_enable_i) begin
      mem_q[load_address_i[AW-1:0]] <= load_data_i;
    end
    if (issue) begin
      rd_data_q <= mem_q[pc_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qdata_q[i] <= '0;
        qaddr_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        qdata_q[tail_q] <= rd_data_q;
        qaddr_q[tail_q] <= rd_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboard bench: the driver queues the expected fetch stream after each
// restart point, and a negedge monitor checks every accepted handshake.
module tb_instruction_prefetch_queue;

  localparam int L     = 16;
  localparam int AW    = 6;
  localparam int QD    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [L-1:0]  load_addr = '0;
  logic [L-1:0]  load_data = '0;
  logic          redirect = 1'b0;
  logic [L-1:0]  redir_addr = '0;
  logic          ready = 1'b0;
  logic          valid;
  logic [L-1:0]  instr;
  logic [L-1:0]  iaddr;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [L-1:0]  mdl_mem [DEPTH];
  logic [31:0]   sb [$];

  instruction_prefetch_queue #(.l(L), .AW(AW), .QDEPTH(QD)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .load_enable_i         (load_en),
    .load_address_i        (load_addr),
    .load_data_i           (load_data),
    .redirect_i            (redirect),
    .redirect_address_i    (redir_addr),
    .ready_i               (ready),
    .valid_o               (valid),
    .instruction_o         (instr),
    .instruction_address_o (iaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream from a restart: consecutive addresses, data from the image.
  task automatic expect_stream(input logic [L-1:0] start);
    logic [L-1:0] a;
    sb.delete();
    for (int i = 0; i < 512; i++) begin
      a = start + L'(i);
      sb.push_back({a, mdl_mem[a[AW-1:0]]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [L-1:0] a);
    redir_addr = a;
    redirect   = 1'b1;
    expect_stream(a);
    step(1);
    redirect   = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && !redirect && valid && ready) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h/%h expected none", iaddr, instr);
      end else begin
        e = sb.pop_front();
        check("pop_addr", 32'(iaddr), 32'(e[31:16]));
        check("pop_instr", 32'(instr), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #2;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_instr", 32'(instr), 32'd0);
    check("reset_addr", 32'(iaddr), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i] = 16'h1000 + 16'(i);
      load_en    = 1'b1;
      load_addr  = 16'(i);
      load_data  = mdl_mem[i];
      step(1);
    end
    load_en = 1'b0;

    // Startup latency and streaming throughput
    expect_stream('0);
    ready = 1'b1;
    rst   = 1'b0;
    step(1);
    check("latency_edge1_valid", 32'(valid), 32'd0);
    step(1);
    check("latency_edge2_valid", 32'(valid), 32'd1);
    check("first_addr", 32'(iaddr), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("throughput_valid", 32'(valid), 32'd1);
    end

    // Fill with Ready low, then drain in order
    rst   = 1'b1;
    ready = 1'b0;
    expect_stream('0);
    step(1);
    rst = 1'b0;
    step(8);
    check("full_valid", 32'(valid), 32'd1);
    check("full_head_addr", 32'(iaddr), 32'd0);
    check("full_head_instr", 32'(instr), 32'h1000);
    ready = 1'b1;
    step(12);

    // Redirect flushes the queue
    do_redirect(16'd5);
    check("redir_edge0_valid", 32'(valid), 32'd0);
    step(1);
    check("redir_edge1_valid", 32'(valid), 32'd0);
    step(1);
    check("redir_edge2_valid", 32'(valid), 32'd1);
    check("redir_addr", 32'(iaddr), 32'd5);
    check("redir_instr", 32'(instr), 32'h1005);
    step(4);

    // Index wrap at the end of memory
    do_redirect(16'd62);
    step(2);
    check("wrap_first_addr", 32'(iaddr), 32'd62);
    step(6);

    // Loads mid-stream stall issue but keep draining
    do_redirect(16'd20);
    step(5);
    load_en = 1'b1;
    load_addr = 16'd2; load_data = 16'hBEEF; mdl_mem[2] = 16'hBEEF;
    step(1);
    load_addr = 16'd3; load_data = 16'($urandom); mdl_mem[3] = load_data;
    step(1);
    load_addr = 16'd4; load_data = 16'($urandom); mdl_mem[4] = load_data;
    step(1);
    load_en = 1'b0;
    check("load_blocks_issue", 32'(valid), 32'd0);
    step(4);
    do_redirect(16'd2);
    step(2);
    check("loaded_addr", 32'(iaddr), 32'd2);
    check("loaded_instr", 32'(instr), 32'hBEEF);
    step(4);

    // Random backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        do_redirect(16'($urandom));
      end else begin
        step(1);
      end
    end
    ready = 1'b1;
    step(6);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    expect_stream('0);
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_addr", 32'(iaddr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_addr", 32'(iaddr), 32'd0);
    check("post_rst_instr", 32'(instr), 32'h1000);
    step(8);

    checks++;
    if (pops < 100) begin
      errors++;
      $display("FAIL pop_count: got %0d expected at least 100", pops);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
